// File: rtl/fifo_uart_tx.sv
// Drains 9-bit words from a first-word-fall-through FIFO and sends each one as
// an async serial frame: start bit, 9 data bits LSB first, then 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [8:0] fifoDO,
  input  logic       fifoEmpty,
  input  logic       txEn,
  output logic       fifoRdEn,
  output logic       txd,
  output logic       busy,
  output logic       frameDone,
  output logic [1:0] dbg_state
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'd8;
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic baud_end;
  logic stop_last;
  logic pop;

  assign baud_end  = (baud_q == BAUD_LAST);
  assign stop_last = (state_q == S_STOP) && baud_end && (bit_q == STOP_LAST);
  // Popping in the final stop cycle lets the next start bit follow with no gap.
  assign pop       = ((state_q == S_IDLE) || stop_last) && txEn && !fifoEmpty && resetN;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            state_d = S_STOP;
            bit_d   = '0;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = fifoDO;
    end

    // The line is registered, so it is driven from the state being entered.
    unique case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  assign fifoRdEn  = pop;
  assign txd       = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign frameDone = stop_last;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit, one with 2,
// each fed from a queue that behaves like a FWFT FIFO.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetN;

  logic [8:0] do1, do2;
  logic       empty1, empty2, en1, en2;
  logic       rd1, txd1, busy1, done1;
  logic       rd2, txd2, busy2, done2;
  logic [1:0] st1, st2;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) u1 (
    .clk(clk), .resetN(resetN), .fifoDO(do1), .fifoEmpty(empty1), .txEn(en1),
    .fifoRdEn(rd1), .txd(txd1), .busy(busy1), .frameDone(done1), .dbg_state(st1)
  );

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) u2 (
    .clk(clk), .resetN(resetN), .fifoDO(do2), .fifoEmpty(empty2), .txEn(en2),
    .fifoRdEn(rd2), .txd(txd2), .busy(busy2), .frameDone(done2), .dbg_state(st2)
  );

  logic [8:0] q1[$];
  logic [8:0] q2[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic       s_rd[2], s_txd[2], s_busy[2], s_done[2];
  logic [1:0] s_st[2];

  typedef struct {
    logic [8:0]  word;
    logic [11:0] frame;  // line level per bit period: [0]=start, [9:1]=data, [11:10]=stop
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    empty1 = (q1.size() == 0);
    do1    = (q1.size() != 0) ? q1[0] : 9'h000;
    empty2 = (q2.size() == 0);
    do2    = (q2.size() != 0) ? q2[0] : 9'h000;
  endtask

  // One clock: sample outputs on the falling edge, then retire a pop just after the rising edge.
  task automatic cycle();
    @(negedge clk);
    s_rd[0] = rd1; s_txd[0] = txd1; s_busy[0] = busy1; s_done[0] = done1; s_st[0] = st1;
    s_rd[1] = rd2; s_txd[1] = txd2; s_busy[1] = busy2; s_done[1] = done2; s_st[1] = st2;
    cyc++;
    @(posedge clk);
    #1;
    if (s_rd[0] && q1.size() != 0) void'(q1.pop_front());
    if (s_rd[1] && q2.size() != 0) void'(q2.pop_front());
    drive_fifo();
  endtask

  task automatic wait_pop(input int inst, input string name, output int waited);
    waited = 0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      waited++;
      if (s_rd[inst]) break;
    end
    check(name, 32'(s_rd[inst]), 32'd1);
  endtask

  task automatic check_frame(input int inst, input logic [11:0] frame, input int stops,
                             input int drop_k, input logic last_rd, input string tag);
    int len;
    logic exp_txd;
    len = (10 + stops) * CPB;
    for (int k = 0; k < len; k++) begin
      cycle();
      exp_txd = (k / CPB < 10) ? frame[k / CPB] : 1'b1;
      check({tag, "_txd"},  32'(s_txd[inst]),  32'(exp_txd));
      check({tag, "_busy"}, 32'(s_busy[inst]), 32'd1);
      check({tag, "_done"}, 32'(s_done[inst]), 32'(k == len - 1));
      check({tag, "_rd"},   32'(s_rd[inst]),   (k == len - 1) ? 32'(last_rd) : 32'd0);
      if (k == 0)        check({tag, "_st_start"}, 32'(s_st[inst]), 32'd1);
      if (k == CPB)      check({tag, "_st_data"},  32'(s_st[inst]), 32'd2);
      if (k == 10 * CPB) check({tag, "_st_stop"},  32'(s_st[inst]), 32'd3);
      if (k == drop_k) en1 = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0, p1, bad_txd, bad_rd, bad_busy;

    vecs[0] = '{9'h155, 12'hEAA};
    vecs[1] = '{9'h001, 12'hC02};
    vecs[2] = '{9'h100, 12'hE00};
    vecs[3] = '{9'h0FF, 12'hDFE};
    vecs[4] = '{9'h0AA, 12'hD54};
    vecs[5] = '{9'h1C3, 12'hF86};

    resetN = 1'b0;
    en1 = 1'b1;
    en2 = 1'b0;
    drive_fifo();
    repeat (3) cycle();
    check("rst_txd1",  32'(s_txd[0]),  32'd1);
    check("rst_busy1", 32'(s_busy[0]), 32'd0);
    check("rst_rd1",   32'(s_rd[0]),   32'd0);
    check("rst_done1", 32'(s_done[0]), 32'd0);
    check("rst_st1",   32'(s_st[0]),   32'd0);
    check("rst_txd2",  32'(s_txd[1]),  32'd1);
    check("rst_busy2", 32'(s_busy[1]), 32'd0);
    resetN = 1'b1;
    repeat (2) cycle();

    // Single words into an empty FIFO, table driven
    for (int i = 0; i < 6; i++) begin
      q1.push_back(vecs[i].word);
      drive_fifo();
      wait_pop(0, "vec_pop", w);
      check("vec_pop_latency", 32'(w), 32'd1);
      check_frame(0, vecs[i].frame, 1, -1, 1'b0, "vec");
      cycle();
      check("vec_idle_busy", 32'(s_busy[0]), 32'd0);
      check("vec_idle_txd",  32'(s_txd[0]),  32'd1);
      repeat (3) cycle();
    end

    // Back-to-back frames
    q1.push_back(9'h001); q1.push_back(9'h100); q1.push_back(9'h0FF);
    drive_fifo();
    wait_pop(0, "b2b_pop", w);
    p0 = cyc;
    check_frame(0, 12'hC02, 1, -1, 1'b1, "b2b0");
    p1 = cyc;
    check("b2b_spacing0", 32'(p1 - p0), 32'd44);
    check_frame(0, 12'hE00, 1, -1, 1'b1, "b2b1");
    check("b2b_spacing1", 32'(cyc - p1), 32'd44);
    check_frame(0, 12'hDFE, 1, -1, 1'b0, "b2b2");
    cycle();
    check("b2b_idle_busy", 32'(s_busy[0]), 32'd0);

    // Long empty stretch
    bad_txd = 0; bad_rd = 0; bad_busy = 0;
    for (int k = 0; k < 1000; k++) begin
      cycle();
      if (s_txd[0] !== 1'b1) bad_txd++;
      if (s_rd[0] !== 1'b0) bad_rd++;
      if (s_busy[0] !== 1'b0) bad_busy++;
    end
    check("empty_txd_bad",  32'(bad_txd),  32'd0);
    check("empty_rd_bad",   32'(bad_rd),   32'd0);
    check("empty_busy_bad", 32'(bad_busy), 32'd0);

    // txEn dropped during DATA of frame 1
    q1.push_back(9'h1C3); q1.push_back(9'h0AA);
    drive_fifo();
    wait_pop(0, "gate_pop", w);
    check_frame(0, 12'hF86, 1, 10, 1'b0, "gate1");
    bad_rd = 0; bad_busy = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (s_rd[0] !== 1'b0) bad_rd++;
      if (s_busy[0] !== 1'b0) bad_busy++;
    end
    check("gate_no_pop",    32'(bad_rd),     32'd0);
    check("gate_idle",      32'(bad_busy),   32'd0);
    check("gate_fifo_left", 32'(q1.size()),  32'd1);
    en1 = 1'b1;
    cycle();
    check("gate_repop", 32'(s_rd[0]), 32'd1);
    check_frame(0, 12'hD54, 1, -1, 1'b0, "gate2");
    cycle();

    // Reset during data bit 4 of 9'h0AA; 9'h155 waits behind it
    q1.push_back(9'h0AA); q1.push_back(9'h155);
    drive_fifo();
    wait_pop(0, "rstm_pop", w);
    repeat (21) cycle();
    #2 resetN = 1'b0;
    #1;
    check("rstm_txd_async", 32'(txd1),  32'd1);
    check("rstm_busy",      32'(busy1), 32'd0);
    check("rstm_rd",        32'(rd1),   32'd0);
    check("rstm_done",      32'(done1), 32'd0);
    check("rstm_st",        32'(st1),   32'd0);
    bad_rd = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (s_rd[0] !== 1'b0 || s_txd[0] !== 1'b1) bad_rd++;
    end
    check("rstm_held", 32'(bad_rd), 32'd0);
    check("rstm_fifo_left", 32'(q1.size()), 32'd1);
    resetN = 1'b1;
    wait_pop(0, "rstm_repop", w);
    check("rstm_repop_latency", 32'(w), 32'd1);
    check_frame(0, 12'hEAA, 1, -1, 1'b0, "rstm");
    check("rstm_fifo_empty", 32'(q1.size()), 32'd0);

    // Two stop bits on the second instance
    en2 = 1'b1;
    q2.push_back(9'h100); q2.push_back(9'h155);
    drive_fifo();
    wait_pop(1, "stop2_pop", w);
    p0 = cyc;
    check_frame(1, 12'hE00, 2, -1, 1'b1, "stop2a");
    check("stop2_period", 32'(cyc - p0), 32'd48);
    check_frame(1, 12'hEAA, 2, -1, 1'b0, "stop2b");
    cycle();
    check("stop2_idle_busy", 32'(s_busy[1]), 32'd0);
    check("stop2_idle_txd",  32'(s_txd[1]),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Single-clock consumer that drains 9-bit words from the read side of a first-word-fall-through FIFO and serialises each word onto an asynchronous serial line. Frame format: start bit, 9 data bits LSB first (bit 8 is the mark/address bit in 9-bit mode), then 1 or 2 stop bits. It sits on the read-clock side of the dual-clock FIFO. `clk` is the FIFO read clock, and `fifoRdEn` connects to the FIFO read enable.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 2.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

- `clk`  input  1  read-side clock; the block's only clock.
- `resetN`  input  1  asynchronous, active-low reset.
- `fifoDO`  input  9  FIFO head word; valid whenever `fifoEmpty` is 0 (FWFT).
- `fifoEmpty`  input  1  FIFO empty flag.
- `txEn`  input  1  permits new frames to start; a frame already in progress always completes.
- `fifoRdEn`  output  1  pop strobe to FIFO, one cycle per word.
- `txd`  output  1  serial line, idle high, registered.
- `busy`  output  1  high while a frame is in progress.
- `frameDone`  output  1  one-cycle pulse in the last cycle of the final stop bit.

## Operation
- State machine: IDLE, START, DATA, STOP.
- Counters:
  - baud counter: 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT).
  - bit counter: 0..8 in DATA, 0..STOP_BITS-1 in STOP.
- Pop condition `pop`: (state==IDLE, or state==STOP in its last cycle) && txEn && !fifoEmpty && resetN.
  - `fifoRdEn` = `pop`, combinational.
  - On the edge ending a `pop` cycle: shift register ← `fifoDO`, state ← START, baud counter ← 0.
- START: `txd`=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: `txd` = shift[0]. The shift register shifts right once per bit period. After 9 bits the state goes to STOP.
- STOP: `txd`=1 for STOP_BITS×CLKS_PER_BIT cycles. In the last cycle:
  - `frameDone`=1.
  - Next state is START if `pop`, otherwise IDLE.
- `busy` = (state != IDLE).
- `fifoRdEn` is never asserted when `fifoEmpty`=1 or when the block is mid-frame (outside the last STOP cycle). This guarantees FIFO RDERR never fires.
- Reset values, held while `resetN`=0:
  - state IDLE.
  - `txd`=1, `busy`=0, `frameDone`=0, `fifoRdEn`=0.
  - all counters 0.
- Reset asserted mid-frame:
  - `txd` goes high immediately (asynchronous); the partial word is discarded and not re-sent.
  - The popped word is lost, and the FIFO is not re-read.

## Timing
- Latency from a pop cycle (cycle P) to the start bit is 1 cycle: `txd` falls in cycle P+1.
- Frame length: (10+STOP_BITS)×CLKS_PER_BIT cycles, measured from the first start-bit cycle to the last stop-bit cycle inclusive.
- Back-to-back frames have no idle gap. The next start bit follows the last stop cycle directly when the FIFO is non-empty and `txEn`=1.
- Starting from IDLE, a word that appears (`fifoEmpty` falls, sampled in cycle E) is popped in cycle E, so its start bit begins in E+1.
- `txEn` is sampled only in pop-eligible cycles. Deasserting it mid-frame has no effect until the frame ends.
- `fifoEmpty` or `fifoDO` changing mid-frame is ignored. The word is already held in the shift register.

## Test plan
- **Single word.** CLKS_PER_BIT=4, STOP_BITS=1; push 9'h155 into an empty FIFO.
  - One `fifoRdEn` pulse.
  - `txd` shows 0 for 4 cycles, then bits 1,0,1,0,1,0,1,0,1 at 4 cycles each, then 1 for 4 cycles.
  - `frameDone` pulses at cycle 44 after the pop; `busy` is high for exactly 44 cycles.
- **Back-to-back.** Preload 9'h001, 9'h100, 9'h0FF.
  - 3 pops spaced exactly 44 cycles apart.
  - Continuous frames with no high gap beyond the stop bit.
  - Decoded words match in order.
- **Empty FIFO.** Hold `fifoEmpty`=1 for 1000 cycles.
  - `txd`=1, `fifoRdEn`=0, `busy`=0 throughout.
- **txEn gating.** Preload 2 words; drop `txEn` during the DATA phase of frame 1.
  - Frame 1 completes intact; no second pop.
  - Raising `txEn` again causes the pop on that cycle, and frame 2 starts 1 cycle later.
- **Reset mid-frame.** Assert `resetN`=0 during bit 4 of 9'h0AA.
  - `txd`=1 asynchronously and all outputs return to reset values.
  - After release with a non-empty FIFO, the next word is popped and sent cleanly.
- **Two stop bits.** STOP_BITS=2, CLKS_PER_BIT=4, 2 preloaded words.
  - Stop high for 8 cycles; frame period 48 cycles.
  - `frameDone` pulses only at the end of the second stop bit.
